// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Wait-stated data memory for the MEM stage of a pipelined core. A request is
// captured in IDLE, held for WAIT_CYCLES extra cycles, performed on the
// WAIT-to-DONE edge and acknowledged for exactly one cycle in DONE. stallM
// holds the pipeline from the accepting cycle until the DONE cycle.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low (memory contents are kept)
//   memreqM     access request valid
//   memwriteM   1 = store, 0 = load
//   byteM       1 = byte access (sb/lb), 0 = word access
//   addrM       byte address; word index [31:2], byte lane [1:0]
//   writeDataM  store data; a byte store uses [7:0]
//   readDataM   load result, registered, valid while ackM = 1
//   stallM      combinational stall to the hazard unit
//   ackM        one-cycle completion pulse
//   errM        access fault (misaligned word or index out of range)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic        byteM,
    input  logic [31:0] addrM,
    input  logic [31:0] writeDataM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        ackM,
    output logic        errM
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0]      DEPTH_LIMIT = 32'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateType;

    stateType         state, nextState;
    logic [CNT_W-1:0] waitCnt, nextCnt;
    logic             capture;
    logic             access;

    // Request fields captured on acceptance; the access only uses these.
    logic [31:0] capAddr;
    logic [31:0] capData;
    logic        capWrite;
    logic        capByte;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] memIdx;
    logic [1:0]       lane;
    logic             misaligned;
    logic             outOfRange;
    logic             fault;
    logic [31:0]      memWord;
    logic [7:0]       laneByte;
    logic [31:0]      loadData;
    logic             doWrite;

    // NOTE: every signal gets a default before the case, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        nextState = state;
        nextCnt   = waitCnt;
        capture   = 1'b0;
        access    = 1'b0;
        unique case (state)
            IDLE: begin
                if (memreqM) begin
                    nextState = WAIT;
                    nextCnt   = CNT_LOAD;
                    capture   = 1'b1;
                end
            end
            WAIT: begin
                if (waitCnt != '0) begin
                    nextCnt = waitCnt - CNT_W'(1);
                end else begin
                    nextState = DONE;
                    access    = 1'b1;
                end
            end
            DONE: begin
                // memreqM is deliberately ignored here.
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign stallM = ((state == IDLE) && memreqM) || (state == WAIT);
    assign ackM   = (state == DONE);

    // Decode of the captured request.
    assign memIdx     = capAddr[IDX_W+1:2];
    assign lane       = capAddr[1:0];
    assign misaligned = !capByte && (lane != 2'b00);
    assign outOfRange = {2'b00, capAddr[31:2]} >= DEPTH_LIMIT;
    assign fault      = misaligned || outOfRange;
    assign memWord    = mem[memIdx];
    assign laneByte   = memWord[{lane, 3'b000} +: 8];
    assign loadData   = capByte ? {{24{laneByte[7]}}, laneByte} : memWord;

    // Gating with rst_n makes a reset on the access edge abort the store.
    assign doWrite = rst_n && access && capWrite && !fault;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            readDataM <= '0;
            errM      <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
            if (access) begin
                errM      <= fault;
                // Stores and faults return zero; loads return the lane/word.
                readDataM <= (fault || capWrite) ? '0 : loadData;
            end
        end
    end

    // Capture registers need no reset: they are only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            capAddr  <= addrM;
            capData  <= writeDataM;
            capWrite <= memwriteM;
            capByte  <= byteM;
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst_n, and a
    // reset-per-word would also prevent mapping it onto RAM.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            if (capByte) begin
                mem[memIdx][{lane, 3'b000} +: 8] <= capData[7:0];
            end else begin
                mem[memIdx] <= capData;
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the data store.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait-state cycles per access.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 memreqM  in  1  MEM-stage access request valid.
REQ-007 memwriteM  in  1  1 = store, 0 = load.
REQ-008 byteM  in  1  1 = byte access (sb/lb), 0 = word access.
REQ-009 addrM  in  32  byte address (aluoutM).
REQ-010 writeDataM  in  32  store data; byte store uses [7:0].
REQ-011 readDataM  out  32  load result, valid while ackM=1.
REQ-012 stallM  out  1  combinational pipeline stall to the hazard unit.
REQ-013 ackM  out  1  one-cycle completion pulse.
REQ-014 errM  out  1  access fault, valid while ackM=1.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and DONE.
REQ-016 IDLE with memreqM=1 SHALL capture addrM, writeDataM, memwriteM and byteM, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-017 WAIT with counter>0 SHALL decrement the counter and stay in WAIT.
REQ-018 WAIT with counter==0 SHALL perform the access on the captured fields and go to DONE.
REQ-019 DONE SHALL return to IDLE unconditionally, and memreqM SHALL be ignored in DONE.
REQ-020 Latency: request accepted in cycle 0 SHALL give ackM=1 in cycle WAIT_CYCLES+2; with WAIT_CYCLES=0, ackM is in cycle 2.
REQ-021 stallM SHALL equal (state==IDLE and memreqM) or state==WAIT, and SHALL be 0 in DONE.
REQ-022 The requester SHALL hold request inputs stable while stallM=1; the block uses only captured values.
REQ-023 Word index SHALL be addrM[31:2]; byte lane SHALL be addrM[1:0], little-endian (lane 0 = bits [7:0]).
REQ-024 A word load SHALL return the full word.
REQ-025 A byte load SHALL return the selected byte sign-extended to 32 bits.
REQ-026 A word store SHALL write all 32 bits.
REQ-027 A byte store SHALL write only the selected lane from writeDataM[7:0] and leave the other lanes unchanged.
REQ-028 A fault SHALL be a word access with addrM[1:0]!=0, or a word index >= DEPTH_WORDS.
REQ-029 On a fault: no memory write, readDataM=0, errM=1 together with ackM.
REQ-030 The memory write SHALL occur only on the single WAIT-to-DONE transition edge.
REQ-031 readDataM and errM SHALL be registered and held until the next ackM; ackM SHALL be 0 outside DONE.
REQ-032 Back-to-back requests SHALL each take WAIT_CYCLES+3 cycles from acceptance to the next acceptance, with no request lost.

Reset
REQ-033 On rst_n=0 at a clock edge: state=IDLE, counter=0, ackM=0, errM=0, readDataM=0.
REQ-034 stallM SHALL then follow REQ-021 combinationally.
REQ-035 Reset SHALL NOT clear memory contents.
REQ-036 Reset asserted during WAIT SHALL abort the access: no write, no ackM.
REQ-037 After rst_n returns high, the first request SHALL be accepted in IDLE normally.

Verification
REQ-038 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> readDataM=0xDEADBEEF, errM=0, ackM in cycle 4 after acceptance (WAIT_CYCLES=2).
REQ-039 Byte store 0x80 to 0x11 over word 0x00000000, then word load 0x10 -> 0x00008000; byte load 0x11 -> 0xFFFFFF80; byte load 0x10 -> 0x00000000.
REQ-040 Word load at 0x13 or word store at 4*DEPTH_WORDS -> errM=1, readDataM=0, memory unchanged on a later aligned read.
REQ-041 memreqM held high for 3 consecutive requests -> stallM high cycles 0-3 of each, exactly 3 ackM pulses 5 cycles apart.
REQ-042 Store 0x12345678 to 0x20 with rst_n=0 in the first WAIT cycle -> no ackM; a later load of 0x20 returns the pre-reset value.
REQ-043 WAIT_CYCLES=0 build: load request -> ackM in cycle 2, stallM high cycles 0-1 only.
